// File: rtl/conv_arbiter.sv
// conv_arbiter: round-robin front end that shares one ConvUnit among NREQ requesters.
// Exactly one job is in flight; its result is returned only to the requester that issued it.
module conv_arbiter #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 64,
  parameter int LEN    = 4,
  parameter int RES_W  = 128,
  parameter int CNT_W  = 16,
  localparam int ID_W  = $clog2(NREQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*DATA_W-1:0]     req_data,
  input  logic [NREQ*LEN*DATA_W-1:0] req_kernel,
  output logic [NREQ-1:0]            rsp_valid,
  input  logic [NREQ-1:0]            rsp_ready,
  output logic [RES_W-1:0]           rsp_result,
  output logic [DATA_W-1:0]          cu_in_data,
  output logic [LEN*DATA_W-1:0]      cu_kernel,
  output logic                       cu_in_valid,
  input  logic                       cu_in_ready,
  input  logic [RES_W-1:0]           cu_result,
  input  logic                       cu_out_valid,
  output logic                       cu_out_ready,
  output logic [ID_W-1:0]            grant_id,
  output logic                       busy,
  output logic [CNT_W-1:0]           done_count
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  logic [1:0]            state_r;
  logic [1:0]            state_nxt_s;
  logic [ID_W-1:0]       rr_ptr_r;
  logic [ID_W-1:0]       grant_r;
  logic [ID_W-1:0]       win_s;
  logic [ID_W-1:0]       cand_s;
  logic                  win_found_s;
  logic                  accept_s;
  logic                  result_hs_s;
  logic                  rsp_hs_s;
  logic [NREQ-1:0]       req_ready_s;
  logic [NREQ-1:0]       rsp_valid_r;
  logic                  cu_in_valid_r;
  logic                  cu_out_ready_r;
  logic                  busy_r;
  logic [CNT_W-1:0]      done_cnt_r;
  logic [DATA_W-1:0]     data_r;
  logic [LEN*DATA_W-1:0] kernel_r;
  logic [RES_W-1:0]      result_r;

  function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base, input int step);
    int pos;
    pos = (int'(base) + step) % NREQ;
    return ID_W'(pos);
  endfunction

  function automatic logic [NREQ-1:0] one_hot(input logic [ID_W-1:0] idx);
    logic [NREQ-1:0] vec;
    vec      = {NREQ{1'b0}};
    vec[idx] = 1'b1;
    return vec;
  endfunction

  // Round-robin winner: first valid requester scanning from just after the last grant.
  always_comb begin
    win_s       = {ID_W{1'b0}};
    win_found_s = 1'b0;
    cand_s      = {ID_W{1'b0}};
    for (int k = 1; k <= NREQ; k++) begin
      cand_s = rr_index(rr_ptr_r, k);
      if (!win_found_s && req_valid[cand_s]) begin
        win_s       = cand_s;
        win_found_s = 1'b1;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Accept strobe towards the winner, only while idle.
  always_comb begin
    req_ready_s = {NREQ{1'b0}};
    if ((state_r == ST_IDLE) && win_found_s) begin
      req_ready_s = one_hot(win_s);
    end else begin
      req_ready_s = {NREQ{1'b0}};
    end
  end

  assign accept_s    = (state_r == ST_IDLE) && win_found_s;
  assign result_hs_s = (state_r == ST_WAIT) && cu_out_valid;
  assign rsp_hs_s    = (state_r == ST_RESP) && rsp_ready[grant_r];

  // Job sequencing: accept, issue to ConvUnit, wait for result, return it.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (win_found_s) state_nxt_s = ST_ISSUE;
        else             state_nxt_s = ST_IDLE;
      end
      ST_ISSUE: begin
        if (cu_in_ready) state_nxt_s = ST_WAIT;
        else             state_nxt_s = ST_ISSUE;
      end
      ST_WAIT: begin
        if (cu_out_valid) state_nxt_s = ST_RESP;
        else              state_nxt_s = ST_WAIT;
      end
      ST_RESP: begin
        if (rsp_ready[grant_r]) state_nxt_s = ST_IDLE;
        else                    state_nxt_s = ST_RESP;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Control state and handshake outputs, registered from the next state so they never glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      rr_ptr_r       <= ID_W'(NREQ - 1);
      grant_r        <= {ID_W{1'b0}};
      cu_in_valid_r  <= 1'b0;
      cu_out_ready_r <= 1'b0;
      busy_r         <= 1'b0;
      rsp_valid_r    <= {NREQ{1'b0}};
      done_cnt_r     <= {CNT_W{1'b0}};
    end else begin
      state_r        <= state_nxt_s;
      cu_in_valid_r  <= (state_nxt_s == ST_ISSUE);
      cu_out_ready_r <= (state_nxt_s == ST_WAIT);
      busy_r         <= (state_nxt_s != ST_IDLE);
      rsp_valid_r    <= (state_nxt_s == ST_RESP) ? one_hot(grant_r) : {NREQ{1'b0}};
      if (accept_s) begin
        rr_ptr_r <= win_s;
        grant_r  <= win_s;
      end else begin
        rr_ptr_r <= rr_ptr_r;
        grant_r  <= grant_r;
      end
      if (rsp_hs_s) done_cnt_r <= done_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      else          done_cnt_r <= done_cnt_r;
    end
  end

  // Payload is captured at accept so requesters may change their inputs afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r   <= {DATA_W{1'b0}};
      kernel_r <= {(LEN*DATA_W){1'b0}};
      result_r <= {RES_W{1'b0}};
    end else begin
      if (accept_s) begin
        data_r   <= req_data[win_s*DATA_W +: DATA_W];
        kernel_r <= req_kernel[win_s*LEN*DATA_W +: LEN*DATA_W];
      end else begin
        data_r   <= data_r;
        kernel_r <= kernel_r;
      end
      if (result_hs_s) result_r <= cu_result;
      else             result_r <= result_r;
    end
  end

  assign req_ready    = req_ready_s;
  assign rsp_valid    = rsp_valid_r;
  assign rsp_result   = result_r;
  assign cu_in_data   = data_r;
  assign cu_kernel    = kernel_r;
  assign cu_in_valid  = cu_in_valid_r;
  assign cu_out_ready = cu_out_ready_r;
  assign grant_id     = grant_r;
  assign busy         = busy_r;
  assign done_count   = done_cnt_r;

endmodule

// File: tb/tb_conv_arbiter.sv
// Scoreboard bench for conv_arbiter: random requesters, a behavioural ConvUnit and an
// independent arbitration model; responses are popped and compared by a separate monitor.
`timescale 1ns/1ps
module tb_conv_arbiter;
  localparam int NREQ   = 4;
  localparam int DATA_W = 64;
  localparam int LEN    = 4;
  localparam int RES_W  = 128;
  localparam int CNT_W  = 4;
  localparam int ID_W   = 2;

  logic                       clk = 1'b0;
  logic                       rst;
  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0]            req_ready;
  logic [NREQ*DATA_W-1:0]     req_data;
  logic [NREQ*LEN*DATA_W-1:0] req_kernel;
  logic [NREQ-1:0]            rsp_valid;
  logic [NREQ-1:0]            rsp_ready;
  logic [RES_W-1:0]           rsp_result;
  logic [DATA_W-1:0]          cu_in_data;
  logic [LEN*DATA_W-1:0]      cu_kernel;
  logic                       cu_in_valid;
  logic                       cu_in_ready;
  logic [RES_W-1:0]           cu_result;
  logic                       cu_out_valid;
  logic                       cu_out_ready;
  logic [ID_W-1:0]            grant_id;
  logic                       busy;
  logic [CNT_W-1:0]           done_count;

  conv_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .LEN(LEN), .RES_W(RES_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_kernel(req_kernel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .cu_in_data(cu_in_data), .cu_kernel(cu_kernel), .cu_in_valid(cu_in_valid),
    .cu_in_ready(cu_in_ready), .cu_result(cu_result), .cu_out_valid(cu_out_valid),
    .cu_out_ready(cu_out_ready), .grant_id(grant_id), .busy(busy), .done_count(done_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ID_W-1:0]  id;
    logic [RES_W-1:0] res;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$];
  int   checks = 0;
  int   passed = 0;

  // reference-model state
  bit                    outstanding = 1'b0;
  int                    last_g = NREQ - 1;
  int                    cnt = 0;
  int                    done_jobs = 0;
  bit                    post_reset = 1'b0;
  bit                    accepted_prev = 1'b0;
  int                    cur_owner = 0;
  logic [DATA_W-1:0]     cur_data = '0;
  logic [LEN*DATA_W-1:0] cur_kernel = '0;
  int                    issue_cycles = 0;

  // ConvUnit behaviour knobs
  bit                    cu_rand = 1'b0;
  bit                    cu_hold = 1'b0;
  int                    cu_stall = 0;
  bit                    dir_en = 1'b0;
  logic [DATA_W-1:0]     dir_data = '0;

  // ConvUnit function: weighted sum of (data ^ j) * kernel[j], modulo 2^RES_W
  function automatic logic [RES_W-1:0] conv_ref(input logic [DATA_W-1:0] d,
                                                input logic [LEN*DATA_W-1:0] k);
    logic [RES_W-1:0] acc;
    acc = '0;
    for (int j = 0; j < LEN; j++)
      acc = acc + RES_W'(d ^ DATA_W'(j)) * RES_W'(k[j*DATA_W +: DATA_W]);
    return acc;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // One bench cycle: drive at the falling edge, then check against the model.
  task automatic cycle(input logic [NREQ-1:0] rv, input logic [NREQ-1:0] rr, input logic r);
    int g;
    exp_t e;
    @(negedge clk);
    rst = r;
    req_valid = rv;
    rsp_ready = rr;
    for (int i = 0; i < NREQ; i++) begin
      req_data[i*DATA_W +: DATA_W] = {$urandom, $urandom};
      for (int j = 0; j < LEN; j++)
        req_kernel[(i*LEN+j)*DATA_W +: DATA_W] = {$urandom, $urandom};
    end
    if (dir_en) req_data[2*DATA_W +: DATA_W] = dir_data;
    #2;
    if (r) begin
      outstanding = 1'b0; last_g = NREQ - 1; cnt = 0; done_jobs = 0;
      sb.delete(); post_reset = 1'b1; accepted_prev = 1'b0;
      return;
    end
    if (post_reset) begin
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_result", rsp_result, 0);
      chk("rst_cu_in_data", cu_in_data, 0);
      chk("rst_cu_kernel", cu_kernel, 0);
      chk("rst_cu_in_valid", cu_in_valid, 0);
      chk("rst_cu_out_ready", cu_out_ready, 0);
      chk("rst_grant_id", grant_id, 0);
      chk("rst_done_count", done_count, 0);
      post_reset = 1'b0;
    end
    chk("busy", busy, outstanding);
    if (accepted_prev) begin
      chk("issue_latency", cu_in_valid, 1);
      chk("grant_id", grant_id, cur_owner);
    end
    if (cu_in_valid) begin
      issue_cycles++;
      chk("cu_in_data", cu_in_data, cur_data);
      chk("cu_kernel", cu_kernel, cur_kernel);
    end
    g = -1;
    if (!outstanding)
      for (int k = 1; k <= NREQ; k++)
        if (g < 0 && rv[ID_W'((last_g + k) % NREQ)]) g = (last_g + k) % NREQ;
    chk("req_ready", req_ready, (g >= 0) ? (256'd1 << g) : 256'd0);
    accepted_prev = (g >= 0);
    if (g >= 0) begin
      outstanding  = 1'b1;
      last_g       = g;
      cur_owner    = g;
      cur_data     = req_data[g*DATA_W +: DATA_W];
      cur_kernel   = req_kernel[g*LEN*DATA_W +: LEN*DATA_W];
      issue_cycles = 0;
      e.id         = ID_W'(g);
      e.res        = conv_ref(cur_data, cur_kernel);
      sb.push_back(e);
      grant_log.push_back(g);
    end
  endtask

  task automatic run_until_idle(input logic [NREQ-1:0] rv, input logic [NREQ-1:0] rr);
    int n;
    n = 0;
    do begin
      cycle(rv, rr, 1'b0);
      n++;
    end while (outstanding && n < 300);
    if (outstanding) chk("idle_timeout", outstanding, 0);
  endtask

  // Behavioural ConvUnit: accepts a job, answers after a delay, emits junk when it has no job.
  initial begin : cu_model
    bit                    have_job;
    bit                    lat_chk;
    int                    delay;
    logic [DATA_W-1:0]     jd;
    logic [LEN*DATA_W-1:0] jk;
    have_job = 1'b0; lat_chk = 1'b0; delay = 0; jd = '0; jk = '0;
    cu_in_ready = 1'b0; cu_out_valid = 1'b0; cu_result = '0;
    forever begin
      @(negedge clk); #1;
      if (rst) begin
        have_job = 1'b0; lat_chk = 1'b0;
        cu_in_ready = 1'b0; cu_out_valid = 1'b0;
      end else begin
        if (lat_chk) chk("result_latency", rsp_valid != 0, 1);
        lat_chk = 1'b0;
        if (have_job) begin
          if (!cu_out_valid) begin
            if (delay == 0 && !cu_hold) begin
              cu_out_valid = 1'b1;
              cu_result    = conv_ref(jd, jk);
            end else if (delay > 0) begin
              delay--;
            end
          end
          if (cu_out_valid && cu_out_ready) begin
            have_job = 1'b0;
            lat_chk  = 1'b1;
          end
          cu_in_ready = cu_rand ? ($urandom_range(0, 1) == 1) : 1'b0;
        end else begin
          cu_out_valid = cu_rand ? ($urandom_range(0, 1) == 1) : 1'b0;
          cu_result    = {$urandom, $urandom, $urandom, $urandom};
          if (cu_stall > 0 && cu_in_valid) begin
            cu_in_ready = 1'b0;
            cu_stall--;
          end else begin
            cu_in_ready = cu_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
          end
          if (cu_in_valid && cu_in_ready) begin
            have_job     = 1'b1;
            jd           = cu_in_data;
            jk           = cu_kernel;
            delay        = cu_rand ? $urandom_range(0, 4) : 2;
            cu_out_valid = 1'b0;
          end
        end
      end
    end
  end

  // Response monitor: pops the scoreboard whenever the DUT presents a result.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk); #3;
      if (!rst && rsp_valid != 0) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", rsp_valid, 0);
        end else begin
          e = sb[0];
          chk("rsp_owner", rsp_valid, 256'd1 << e.id);
          chk("rsp_result", rsp_result, e.res);
          if (rsp_ready[e.id]) begin
            chk("done_count", done_count, cnt);
            void'(sb.pop_front());
            cnt         = (cnt + 1) % (1 << CNT_W);
            done_jobs++;
            outstanding = 1'b0;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int               n;
    int               exp5[5];
    logic [NREQ-1:0]  v0;
    logic [RES_W-1:0] r0;
    exp5 = '{0, 1, 2, 3, 0};
    rst = 1'b1; req_valid = '0; rsp_ready = '0; req_data = '0; req_kernel = '0;
    cycle(4'b0000, 4'b0000, 1'b1);
    cycle(4'b0000, 4'b0000, 1'b1);
    cycle(4'b0000, 4'b0000, 1'b0);

    // single request from requester 2 with a fixed payload
    dir_en = 1'b1; dir_data = 64'hDEAD_BEEF_0000_0001;
    cycle(4'b0100, 4'b1111, 1'b0);
    chk("t1_grant", (grant_log.size() > 0) ? grant_log[$] : 99, 2);
    chk("t1_payload", cur_data, 64'hDEAD_BEEF_0000_0001);
    dir_en = 1'b0;
    run_until_idle(4'b0000, 4'b1111);

    // all requesters held valid: fair rotation and count wrap after 17 jobs
    cycle(4'b0000, 4'b0000, 1'b1);
    grant_log.delete();
    n = 0;
    while (done_jobs < 17 && n < 400) begin
      cycle(4'b1111, 4'b1111, 1'b0);
      n++;
    end
    cycle(4'b1111, 4'b1111, 1'b0);
    chk("t6_done_jobs", done_jobs, 17);
    chk("t6_done_wrap", done_count, 1);
    chk("t2_log_size", grant_log.size() >= 5, 1);
    if (grant_log.size() >= 5)
      for (int i = 0; i < 5; i++) chk("t2_grant_seq", grant_log[i], exp5[i]);
    run_until_idle(4'b0000, 4'b1111);

    // response back-pressure
    n = 0;
    do begin
      cycle(4'b1111, 4'b0000, 1'b0);
      n++;
    end while (rsp_valid == 0 && n < 50);
    v0 = rsp_valid;
    r0 = rsp_result;
    chk("t3_rsp_seen", v0 != 0, 1);
    for (int i = 0; i < 5; i++) begin
      cycle(4'b1111, 4'b0000, 1'b0);
      chk("t3_rsp_valid_hold", rsp_valid, v0);
      chk("t3_rsp_result_hold", rsp_result, r0);
      chk("t3_req_ready_low", req_ready, 0);
      chk("t3_busy", busy, 1);
    end
    run_until_idle(4'b0000, 4'b1111);

    // ConvUnit input stall for three cycles
    cu_stall = 3;
    cycle(4'b0001, 4'b1111, 1'b0);
    run_until_idle(4'b0000, 4'b1111);
    chk("t4_issue_cycles", issue_cycles, 4);

    // reset while waiting for a result aborts the job
    cu_hold = 1'b1;
    cycle(4'b1000, 4'b1111, 1'b0);
    n = 0;
    do begin
      cycle(4'b0000, 4'b1111, 1'b0);
      n++;
    end while (!cu_out_ready && n < 20);
    chk("t5_in_wait", cu_out_ready, 1);
    cycle(4'b0000, 4'b0000, 1'b1);
    cu_hold = 1'b0;
    cycle(4'b0000, 4'b0000, 1'b0);
    chk("t5_busy_after_rst", busy, 0);
    cycle(4'b1010, 4'b1111, 1'b0);
    chk("t5_first_grant", (grant_log.size() > 0) ? grant_log[$] : 99, 1);
    run_until_idle(4'b0000, 4'b1111);

    // randomized traffic with a random ConvUnit and one reset in the middle
    cu_rand = 1'b1;
    cycle(4'b0000, 4'b0000, 1'b1);
    n = 0;
    while (done_jobs < 120 && n < 5000) begin
      cycle(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), n == 300);
      n++;
    end
    chk("rand_progress", done_jobs >= 120, 1);
    cu_rand = 1'b0;
    run_until_idle(4'b0000, 4'b1111);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
